// File: rtl/bmp_pkg.sv
// Shared types and constants for the 24-bpp BMP stream parser.
// The optional top-down image support is selected by the BMP_TOPDOWN_EN macro.
package bmp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_SKIP,
    S_PIXEL,
    S_PAD,
    S_DONE,
    S_ERROR
  } state_e;

  // Byte positions of the header fields inside the file
  localparam int OFS_SIG    = 0;
  localparam int OFS_OFFSET = 10;
  localparam int OFS_WIDTH  = 18;
  localparam int OFS_HEIGHT = 22;
  localparam int OFS_BPP    = 28;
  localparam int OFS_COMP   = 30;

  localparam logic [7:0]  BMP_SIG0  = 8'h42;
  localparam logic [7:0]  BMP_SIG1  = 8'h4D;
  localparam logic [15:0] BPP_24    = 16'd24;
  localparam int          HDR_BYTES = 54;

  function automatic logic in_field(input logic [31:0] idx, input int base, input int len);
    return (idx >= 32'(base)) && (idx < 32'(base + len));
  endfunction

endpackage

// File: rtl/bmp_byte_unpacker.sv
// Word-to-byte serializer: holds one little-endian word and hands out bytes 0..3
// under a valid/ready handshake; flush and drain discard whatever is held.
module bmp_byte_unpacker (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        flush_i,
  input  logic        drain_i,
  input  logic [31:0] word_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic        full_q, full_d;
  logic        last_take;

  // A new word may land in the same cycle the last byte of the old one leaves.
  assign last_take    = full_q & byte_ready_i & (idx_q == 2'd3);
  assign word_ready_o = drain_i | flush_i | (en_i & (~full_q | last_take));
  assign byte_valid_o = full_q & ~flush_i & ~drain_i;

  always_comb begin
    byte_o = 8'h00;
    case (idx_q)
      2'd0:    byte_o = word_q[7:0];
      2'd1:    byte_o = word_q[15:8];
      2'd2:    byte_o = word_q[23:16];
      default: byte_o = word_q[31:24];
    endcase
  end

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (flush_i | drain_i) begin
      full_d = 1'b0;
      idx_d  = 2'd0;
    end else begin
      if (full_q & byte_ready_i) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) full_d = 1'b0;
      end
      if (en_i & word_valid_i & word_ready_o) begin
        word_d = word_i;
        full_d = 1'b1;
        idx_d  = 2'd0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= 32'h0;
      idx_q  <= 2'd0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/bmp_stream_parser.sv
// Parses a 24-bpp BMP byte stream into tagged RGB pixel beats (valid/ready).
// Define BMP_TOPDOWN_EN to accept negative heights as top-down images.
module bmp_stream_parser
  import bmp_pkg::*;
#(
  parameter int MAX_WIDTH  = 2048,
  parameter int MAX_HEIGHT = 2048,
  parameter int COORD_W    = 12
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic [31:0]        IN_DATA,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [23:0]        OUT_PIXEL,
  output logic [COORD_W-1:0] OUT_X,
  output logic [COORD_W-1:0] OUT_Y,
  output logic               OUT_SOF,
  output logic               OUT_EOL,
  output logic               OUT_EOF,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [COORD_W:0]   IMG_WIDTH,
  output logic [COORD_W:0]   IMG_HEIGHT,
  output logic               HDR_ERR,
  output logic               DONE,
  output state_e             DBG_STATE
);

  // Handshakes: a word moves when IN_VALID && IN_READY, a byte moves from the
  // unpacker when byte_valid && byte_ready, and a pixel beat moves when
  // OUT_VALID && OUT_READY; OUT_* stays stable while OUT_VALID && !OUT_READY.

  localparam int XW = COORD_W + 1;

  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] off_q, off_d, width_q, width_d, height_q, height_d, comp_q, comp_d;
  logic [15:0] bpp_q, bpp_d;
  logic        sig_bad_q, sig_bad_d;
  logic [1:0]  phase_q, phase_d, pad_cnt_q, pad_cnt_d;
  logic [7:0]  b_q, b_d, g_q, g_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, row_q, row_d;
  logic        frame_last_q, frame_last_d;
  logic [23:0] pix_q, pix_d;
  logic [COORD_W-1:0] ox_q, ox_d, oy_q, oy_d;
  logic        sof_q, sof_d, eol_q, eol_d, eof_q, eof_d, ovalid_q, ovalid_d;

  logic [7:0]  byte_w;
  logic        byte_valid, byte_ready, consume, load;
  logic [31:0] h_abs;
  logic [XW-1:0] w_last, h_last;
  logic        last_x, last_row, topdown, neg_bad, hdr_bad;
  logic [COORD_W-1:0] y_init;

  bmp_byte_unpacker u_unpacker (
    .clk_i        (CLK),
    .rst_ni       (RESET_N),
    .en_i         (state_q != S_IDLE),
    .flush_i      (state_q == S_DONE),
    .drain_i      (state_q == S_ERROR),
    .word_i       (IN_DATA),
    .word_valid_i (IN_VALID),
    .word_ready_o (IN_READY),
    .byte_o       (byte_w),
    .byte_valid_o (byte_valid),
    .byte_ready_i (byte_ready)
  );

  assign consume = byte_valid & byte_ready;
  assign h_abs   = height_q[31] ? (~height_q + 32'd1) : height_q;
  assign w_last  = width_q[COORD_W:0] - XW'(1);
  assign h_last  = h_abs[COORD_W:0] - XW'(1);
  assign last_x  = ({1'b0, x_q} == w_last);
  assign last_row = ({1'b0, row_q} == h_last);

`ifdef BMP_TOPDOWN_EN
  assign topdown = height_q[31];
  assign neg_bad = 1'b0;
`else
  assign topdown = 1'b0;
  assign neg_bad = height_q[31];
`endif

  assign y_init  = topdown ? '0 : h_last[COORD_W-1:0];
  assign hdr_bad = sig_bad_q | (off_q < 32'(HDR_BYTES)) |
                   (width_q == 32'd0) | (width_q > 32'(MAX_WIDTH)) |
                   (h_abs == 32'd0) | (h_abs > 32'(MAX_HEIGHT)) | neg_bad |
                   (bpp_q != BPP_24) | (comp_q != 32'd0);

  always_comb begin
    state_d = state_q;   cnt_d = cnt_q;       off_d = off_q;
    width_d = width_q;   height_d = height_q; comp_d = comp_q;
    bpp_d = bpp_q;       sig_bad_d = sig_bad_q;
    phase_d = phase_q;   pad_cnt_d = pad_cnt_q;
    b_d = b_q;           g_d = g_q;
    x_d = x_q;           y_d = y_q;           row_d = row_q;
    frame_last_d = frame_last_q;
    pix_d = pix_q;       ox_d = ox_q;         oy_d = oy_q;
    sof_d = sof_q;       eol_d = eol_q;       eof_d = eof_q;
    ovalid_d = ovalid_q;
    byte_ready = 1'b0;
    load = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_HEADER;
          cnt_d   = 32'd0;
        end
      end
      S_HEADER: begin
        byte_ready = 1'b1;
        if (consume) begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == 32'(OFS_SIG))     sig_bad_d = (byte_w != BMP_SIG0);
          if (cnt_q == 32'(OFS_SIG + 1)) sig_bad_d = sig_bad_q | (byte_w != BMP_SIG1);
          // Little-endian fields shift in from the top, so byte 0 ends up in [7:0].
          if (in_field(cnt_q, OFS_OFFSET, 4)) off_d    = {byte_w, off_q[31:8]};
          if (in_field(cnt_q, OFS_WIDTH, 4))  width_d  = {byte_w, width_q[31:8]};
          if (in_field(cnt_q, OFS_HEIGHT, 4)) height_d = {byte_w, height_q[31:8]};
          if (in_field(cnt_q, OFS_BPP, 2))    bpp_d    = {byte_w, bpp_q[15:8]};
          if (in_field(cnt_q, OFS_COMP, 4))   comp_d   = {byte_w, comp_q[31:8]};
          if (cnt_q == 32'(HDR_BYTES - 1)) begin
            phase_d = 2'd0;
            x_d     = '0;
            row_d   = '0;
            y_d     = y_init;
            if (hdr_bad)                        state_d = S_ERROR;
            else if (off_q == 32'(HDR_BYTES))   state_d = S_PIXEL;
            else                                state_d = S_SKIP;
          end
        end
      end
      S_SKIP: begin
        byte_ready = 1'b1;
        if (consume) begin
          cnt_d = cnt_q + 32'd1;
          if ((cnt_q + 32'd1) == off_q) state_d = S_PIXEL;
        end
      end
      S_PIXEL: begin
        byte_ready = ~ovalid_q | OUT_READY;
        if (consume) begin
          case (phase_q)
            2'd0: begin b_d = byte_w; phase_d = 2'd1; end
            2'd1: begin g_d = byte_w; phase_d = 2'd2; end
            default: begin
              phase_d = 2'd0;
              load    = 1'b1;
              pix_d   = {byte_w, g_q, b_q};
              ox_d    = x_q;
              oy_d    = y_q;
              sof_d   = (x_q == '0) && (row_q == '0);
              eol_d   = last_x;
              eof_d   = last_x & last_row;
              if (last_x) begin
                x_d          = '0;
                row_d        = row_q + COORD_W'(1);
                y_d          = topdown ? (y_q + COORD_W'(1)) : (y_q - COORD_W'(1));
                frame_last_d = last_row;
                pad_cnt_d    = 2'd0;
                if (width_q[1:0] != 2'd0) state_d = S_PAD;
                else if (last_row)        state_d = S_DONE;
              end else begin
                x_d = x_q + COORD_W'(1);
              end
            end
          endcase
        end
      end
      S_PAD: begin
        byte_ready = 1'b1;
        if (consume) begin
          pad_cnt_d = pad_cnt_q + 2'd1;
          if (pad_cnt_q == (width_q[1:0] - 2'd1))
            state_d = frame_last_q ? S_DONE : S_PIXEL;
        end
      end
      S_ERROR: begin
        byte_ready = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (load)           ovalid_d = 1'b1;
    else if (OUT_READY) ovalid_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;   cnt_q <= 32'd0;     off_q <= 32'd0;
      width_q <= 32'd0;    height_q <= 32'd0;  comp_q <= 32'd0;
      bpp_q <= 16'd0;      sig_bad_q <= 1'b0;
      phase_q <= 2'd0;     pad_cnt_q <= 2'd0;
      b_q <= 8'd0;         g_q <= 8'd0;
      x_q <= '0;           y_q <= '0;          row_q <= '0;
      frame_last_q <= 1'b0;
      pix_q <= 24'd0;      ox_q <= '0;         oy_q <= '0;
      sof_q <= 1'b0;       eol_q <= 1'b0;      eof_q <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;     off_q <= off_d;
      width_q <= width_d;  height_q <= height_d; comp_q <= comp_d;
      bpp_q <= bpp_d;      sig_bad_q <= sig_bad_d;
      phase_q <= phase_d;  pad_cnt_q <= pad_cnt_d;
      b_q <= b_d;          g_q <= g_d;
      x_q <= x_d;          y_q <= y_d;         row_q <= row_d;
      frame_last_q <= frame_last_d;
      pix_q <= pix_d;      ox_q <= ox_d;       oy_q <= oy_d;
      sof_q <= sof_d;      eol_q <= eol_d;     eof_q <= eof_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign OUT_PIXEL  = pix_q;
  assign OUT_X      = ox_q;
  assign OUT_Y      = oy_q;
  assign OUT_SOF    = sof_q;
  assign OUT_EOL    = eol_q;
  assign OUT_EOF    = eof_q;
  assign OUT_VALID  = ovalid_q;
  assign IMG_WIDTH  = width_q[COORD_W:0];
  assign IMG_HEIGHT = h_abs[COORD_W:0];
  assign HDR_ERR    = (state_q == S_ERROR);
  assign DONE       = (state_q == S_DONE);
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_bmp_stream_parser.sv
// Directed bench for bmp_stream_parser: builds BMP files byte by byte, queues the
// expected pixel beats and compares every accepted beat against the queue.
module tb_bmp_stream_parser;
  import bmp_pkg::*;

  localparam int CW = 12;

  logic          CLK, RESET_N, START, IN_VALID, IN_READY, OUT_READY;
  logic [31:0]   IN_DATA;
  logic [23:0]   OUT_PIXEL;
  logic [CW-1:0] OUT_X, OUT_Y;
  logic          OUT_SOF, OUT_EOL, OUT_EOF, OUT_VALID, HDR_ERR, DONE;
  logic [CW:0]   IMG_WIDTH, IMG_HEIGHT;
  state_e        DBG_STATE;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int beats = 0;
  int pad_cycles = 0;
  int cyc = 0;
  bit rdy_stall = 0;
  logic [50:0] exp_q[$];
  logic [50:0] saved_q[$];
  logic [7:0]  fb[$];
  logic [50:0] beat, prev_beat;
  logic        prev_stall;

  bmp_stream_parser dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_PIXEL(OUT_PIXEL), .OUT_X(OUT_X), .OUT_Y(OUT_Y),
    .OUT_SOF(OUT_SOF), .OUT_EOL(OUT_EOL), .OUT_EOF(OUT_EOF),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT),
    .HDR_ERR(HDR_ERR), .DONE(DONE), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  assign beat = {OUT_PIXEL, OUT_X, OUT_Y, OUT_SOF, OUT_EOL, OUT_EOF};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    OUT_READY = rdy_stall ? ((cyc % 3) == 0) : 1'b1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    step();
    exp_q.delete();
    beats = 0;
  endtask

  task automatic start_pulse();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic build(input int off, input int w, input int h, input int bpp,
                       input logic [7:0] sig1, input bit fixed_first, input bit with_pix);
    logic [7:0]  hdr [54];
    logic [31:0] ov, wv, hv, bv;
    logic [7:0]  pb, pg, pr;
    int habs, yy;
    bit sof, eol, eof;
    fb.delete();
    exp_q.delete();
    ov = off; wv = w; hv = h; bv = bpp;
    for (int i = 0; i < 54; i++) hdr[i] = 8'h00;
    hdr[0] = 8'h42; hdr[1] = sig1; hdr[14] = 8'd40; hdr[26] = 8'd1;
    for (int k = 0; k < 4; k++) begin
      hdr[10+k] = ov[8*k +: 8];
      hdr[18+k] = wv[8*k +: 8];
      hdr[22+k] = hv[8*k +: 8];
    end
    hdr[28] = bv[7:0];
    hdr[29] = bv[15:8];
    for (int i = 0; i < 54; i++) fb.push_back(hdr[i]);
    for (int i = 54; i < off; i++) fb.push_back(8'($urandom_range(0, 255)));
    if (with_pix) begin
      habs = (h < 0) ? -h : h;
      for (int r0 = 0; r0 < habs; r0++) begin
        yy = (h < 0) ? r0 : (habs - 1 - r0);
        for (int x = 0; x < w; x++) begin
          if (fixed_first && r0 == 0 && x == 0) begin
            pb = 8'h03; pg = 8'h02; pr = 8'h01;
          end else begin
            pb = 8'($urandom_range(0, 255));
            pg = 8'($urandom_range(0, 255));
            pr = 8'($urandom_range(0, 255));
          end
          fb.push_back(pb); fb.push_back(pg); fb.push_back(pr);
          sof = (r0 == 0) && (x == 0);
          eol = (x == w - 1);
          eof = eol && (r0 == habs - 1);
          exp_q.push_back({pr, pg, pb, 12'(x), 12'(yy), sof, eol, eof});
        end
        for (int p = 0; p < (w % 4); p++) fb.push_back(8'($urandom_range(0, 255)));
      end
    end else begin
      repeat (12) fb.push_back(8'($urandom_range(0, 255)));
    end
    while ((fb.size() % 4) != 0) fb.push_back(8'h00);
  endtask

  task automatic feed(input int nwords);
    int n;
    bit got;
    for (int i = 0; i < nwords; i++) begin
      IN_DATA  = {fb[4*i+3], fb[4*i+2], fb[4*i+1], fb[4*i]};
      IN_VALID = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 1000) begin
        @(negedge CLK);
        got = IN_READY;
        step();
        n++;
      end
      if (!got) begin
        check("feed_timeout", 128'(got), 128'd1);
        break;
      end
    end
    IN_VALID = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!(DONE === 1'b1 && exp_q.size() == 0) && k < budget) begin
      step();
      k++;
    end
    check({tag, "_done"}, 128'(DONE), 128'd1);
    check({tag, "_exp_empty"}, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int k = 0;
    while (beats < n && k < budget) begin
      step();
      k++;
    end
    check({tag, "_beats"}, 128'(beats), 128'(n));
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge CLK) begin
    if (!RESET_N) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", {OUT_VALID, beat}, {1'b1, prev_beat});
      if (OUT_VALID && OUT_READY) begin
        beats++;
        if (exp_q.size() == 0) check("spurious_beat", 128'(OUT_VALID), 128'd0);
        else check("beat", 128'(beat), 128'(exp_q.pop_front()));
      end
      prev_stall = OUT_VALID && !OUT_READY;
      prev_beat  = beat;
      if (DBG_STATE == S_PAD) pad_cycles++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    RESET_N = 1'b0; START = 1'b0; IN_VALID = 1'b0; IN_DATA = 32'h0; OUT_READY = 1'b1;
    step(); step(); step();
    check("reset_outputs",
          128'({IN_READY, OUT_PIXEL, OUT_X, OUT_Y, OUT_SOF, OUT_EOL, OUT_EOF, OUT_VALID,
                IMG_WIDTH, IMG_HEIGHT, HDR_ERR, DONE}), 128'd0);
    check("reset_state", 128'(DBG_STATE), 128'(S_IDLE));
    RESET_N = 1'b1;
    step();

    // 2x2 bottom-up image with 2 pad bytes per row
    beats = 0;
    build(54, 2, 2, 24, 8'h4D, 1'b1, 1'b1);
    start_pulse();
    feed(fb.size() / 4);
    wait_done("img2x2", 200);
    check("img2x2_beats", 128'(beats), 128'd4);
    check("img2x2_width", 128'(IMG_WIDTH), 128'd2);
    check("img2x2_height", 128'(IMG_HEIGHT), 128'd2);
    check("img2x2_err", 128'(HDR_ERR), 128'd0);

    // bad signature
    do_reset();
    build(54, 2, 2, 24, 8'h58, 1'b0, 1'b0);
    start_pulse();
    feed(fb.size() / 4);
    step();
    check("sig_err", 128'(HDR_ERR), 128'd1);
    check("sig_state", 128'(DBG_STATE), 128'(S_ERROR));
    IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("sig_drain_ready", 128'(IN_READY), 128'd1);
      step();
    end
    IN_VALID = 1'b0;
    check("sig_no_beats", 128'(beats), 128'd0);
    check("sig_no_valid", 128'(OUT_VALID), 128'd0);

    // bpp = 32
    do_reset();
    build(54, 2, 2, 32, 8'h4D, 1'b0, 1'b0);
    start_pulse();
    feed(fb.size() / 4);
    step();
    check("bpp_err", 128'(HDR_ERR), 128'd1);

    // width one beyond the maximum
    do_reset();
    build(54, 2049, 2, 24, 8'h4D, 1'b0, 1'b0);
    start_pulse();
    feed(fb.size() / 4);
    step();
    check("width_err", 128'(HDR_ERR), 128'd1);
    check("width_no_beats", 128'(beats), 128'd0);

    // offset 58, width 4: skip 4 bytes, no padding
    do_reset();
    pad_cycles = 0;
    build(58, 4, 2, 24, 8'h4D, 1'b0, 1'b1);
    start_pulse();
    feed(fb.size() / 4);
    wait_done("off58", 300);
    check("off58_beats", 128'(beats), 128'd8);
    check("off58_no_pad", 128'(pad_cycles), 128'd0);

    // 3x3 with 3 pad bytes, stall-free then with OUT_READY high 1 of 3 cycles
    do_reset();
    build(54, 3, 3, 24, 8'h4D, 1'b0, 1'b1);
    saved_q = exp_q;
    start_pulse();
    feed(fb.size() / 4);
    wait_done("w3_free", 300);
    check("w3_free_beats", 128'(beats), 128'd9);
    beats = 0;
    exp_q = saved_q;
    rdy_stall = 1'b1;
    start_pulse();
    feed(fb.size() / 4);
    wait_done("w3_stall", 600);
    check("w3_stall_beats", 128'(beats), 128'd9);
    rdy_stall = 1'b0;
    step();

    // reset after three pixels, then a fresh frame
    do_reset();
    build(54, 4, 2, 24, 8'h4D, 1'b0, 1'b1);
    start_pulse();
    feed(16);
    wait_beats("midrst", 3, 100);
    repeat (5) step();
    check("midrst_only3", 128'(beats), 128'd3);
    RESET_N = 1'b0;
    #1;
    check("midrst_outputs",
          128'({IN_READY, OUT_PIXEL, OUT_X, OUT_Y, OUT_SOF, OUT_EOL, OUT_EOF, OUT_VALID,
                IMG_WIDTH, IMG_HEIGHT, HDR_ERR, DONE}), 128'd0);
    exp_q.delete();
    step();
    RESET_N = 1'b1;
    step();
    beats = 0;
    build(54, 4, 2, 24, 8'h4D, 1'b0, 1'b1);
    start_pulse();
    feed(fb.size() / 4);
    wait_done("midrst_fresh", 300);
    check("midrst_fresh_beats", 128'(beats), 128'd8);

    // negative height
    do_reset();
`ifdef BMP_TOPDOWN_EN
    build(54, 2, -2, 24, 8'h4D, 1'b0, 1'b1);
    start_pulse();
    feed(fb.size() / 4);
    wait_done("topdown", 200);
    check("topdown_beats", 128'(beats), 128'd4);
    check("topdown_height", 128'(IMG_HEIGHT), 128'd2);
`else
    build(54, 2, -2, 24, 8'h4D, 1'b0, 1'b0);
    start_pulse();
    feed(fb.size() / 4);
    step();
    check("negh_err", 128'(HDR_ERR), 128'd1);
    check("negh_no_beats", 128'(beats), 128'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
